io_bus_fabric: RTL and testbench

Parametrised multi-master, multi-slave interconnect that replaces the single-CPU tri-state `busData` path in `top`. Up to M bus masters (CPU data port, debug/DMA engines) contend for one shared device bus. Fair round-robin arbitration, per-slave base/mask address decode, and a bounded wait with timeout ensure a missing or hung device never stalls a master. One transaction is in flight at a time; all slave-side outputs are registered.

---
 rtl/io_bus_fabric.sv | 234 +++++++++++++++++++++++
 tb/tb_io_bus_fabric.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_fabric.sv
// io_bus_fabric
// Shared device-bus interconnect for M masters and S slaves. Requesters are
// served one at a time in round-robin order. The granted request is decoded
// against per-slave base/mask windows and driven onto registered slave-side
// signals. The fabric then waits for the selected slave's ack, or for a
// bounded timeout, and returns a one-cycle ack/err/rdata to the master.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   m_req/m_we        per-master request / write enable      [M]
//   m_addr/m_ctrl     per-master address / ctrl, flattened   [M*AW] / [M*CW]
//   m_wd              per-master write data, flattened       [M*DW]
//   m_ack/m_err       one-cycle completion pulse / error flag [M]
//   m_rd              shared read data, valid with m_ack     [DW]
//   s_sel             one-hot slave select, held for access  [S]
//   s_we/s_addr/s_ctrl/s_wd  registered request fields
//   s_ack             per-slave completion                   [S]
//   s_rd              per-slave read data, flattened         [S*DW]
//
// state  | meaning
// IDLE   | arbitrate, latch request, decode; miss goes straight to RESP
// ACCESS | slave selected; waiting for its ack or the timeout
// RESP   | m_ack/m_err/m_rd presented for one cycle; advance rr_ptr
module io_bus_fabric #(
  parameter int M = 2,
  parameter int S = 4,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = 3,
  parameter logic [S*AW-1:0] SLV_BASE = '0,
  parameter logic [S*AW-1:0] SLV_MASK = '0,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [M-1:0]    m_req,
  input  logic [M-1:0]    m_we,
  input  logic [M*AW-1:0] m_addr,
  input  logic [M*CW-1:0] m_ctrl,
  input  logic [M*DW-1:0] m_wd,
  output logic [M-1:0]    m_ack,
  output logic [M-1:0]    m_err,
  output logic [DW-1:0]   m_rd,
  output logic [S-1:0]    s_sel,
  output logic            s_we,
  output logic [AW-1:0]   s_addr,
  output logic [CW-1:0]   s_ctrl,
  output logic [DW-1:0]   s_wd,
  input  logic [S-1:0]    s_ack,
  input  logic [S*DW-1:0] s_rd
);

  localparam int GW = (M > 1) ? $clog2(M) : 1;
  // The counter only has to reach TIMEOUT-1. With TIMEOUT = 0 it is a
  // 1-bit saturating counter that never terminates the access.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] CNT_TC = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   rr_q, rr_d;
  logic [GW-1:0]   gnt_q, gnt_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [S-1:0]    sel_q, sel_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [CW-1:0]   ctrl_q, ctrl_d;
  logic [DW-1:0]   wd_q, wd_d;
  logic [M-1:0]    ack_q, ack_d;
  logic [M-1:0]    err_q, err_d;
  logic [DW-1:0]   rd_q, rd_d;

  // arbitration result
  logic            found;
  int              arb_j;
  logic [GW-1:0]   pick;
  logic            p_we;
  logic [AW-1:0]   p_addr;
  logic [CW-1:0]   p_ctrl;
  logic [DW-1:0]   p_wd;

  // decode result
  logic            hit_any;
  logic [S-1:0]    hit_oh;

  // selected-slave response
  logic            ack_sel;
  logic [DW-1:0]   rd_sel;

  // Scan upward from rr_q with wrap; the first requester found wins.
  always_comb begin
    found  = 1'b0;
    arb_j  = 0;
    pick   = '0;
    p_we   = 1'b0;
    p_addr = '0;
    p_ctrl = '0;
    p_wd   = '0;
    for (int k = 0; k < M; k++) begin
      arb_j = int'(rr_q) + k;
      if (arb_j >= M) arb_j = arb_j - M;
      if (!found && m_req[arb_j]) begin
        found  = 1'b1;
        pick   = GW'(arb_j);
        p_we   = m_we[arb_j];
        p_addr = m_addr[arb_j*AW +: AW];
        p_ctrl = m_ctrl[arb_j*CW +: CW];
        p_wd   = m_wd[arb_j*DW +: DW];
      end
    end
  end

  // Scanning downward lets the lowest-index hit overwrite higher ones.
  always_comb begin
    hit_any = 1'b0;
    hit_oh  = '0;
    for (int i = S - 1; i >= 0; i--) begin
      if ((p_addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
        hit_any   = 1'b1;
        hit_oh    = '0;
        hit_oh[i] = 1'b1;
      end
    end
  end

  // Only the selected slave's ack and read data are honoured.
  always_comb begin
    ack_sel = |(s_ack & sel_q);
    rd_sel  = '0;
    for (int i = 0; i < S; i++) begin
      if (sel_q[i]) rd_sel = rd_sel | s_rd[i*DW +: DW];
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    ctrl_d  = ctrl_q;
    wd_d    = wd_q;
    ack_d   = '0;
    err_d   = '0;
    rd_d    = '0;

    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d  = pick;
          we_d   = p_we;
          addr_d = p_addr;
          ctrl_d = p_ctrl;
          wd_d   = p_wd;
          if (hit_any) begin
            sel_d   = hit_oh;
            cnt_d   = '0;
            state_d = ACCESS;
          end else begin
            ack_d[pick] = 1'b1;
            err_d[pick] = 1'b1;
            state_d     = RESP;
          end
        end
      end

      ACCESS: begin
        if (ack_sel) begin
          ack_d[gnt_q] = 1'b1;
          rd_d         = we_q ? '0 : rd_sel;
          sel_d        = '0;
          state_d      = RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_TC)) begin
          ack_d[gnt_q] = 1'b1;
          err_d[gnt_q] = 1'b1;
          sel_d        = '0;
          state_d      = RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESP: begin
        rr_d    = (gnt_q == GW'(M - 1)) ? '0 : gnt_q + 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      ctrl_q  <= '0;
      wd_q    <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      ctrl_q  <= ctrl_d;
      wd_q    <= wd_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  assign m_ack  = ack_q;
  assign m_err  = err_q;
  assign m_rd   = rd_q;
  assign s_sel  = sel_q;
  assign s_we   = we_q;
  assign s_addr = addr_q;
  assign s_ctrl = ctrl_q;
  assign s_wd   = wd_q;

endmodule

// File: tb/tb_io_bus_fabric.sv
// Directed bench for io_bus_fabric (M=2, S=4, TIMEOUT=4).
// Slave windows: 0 = 0x0000_0xxx, 1 = 0x0000_1xxx, 2 = 0xFFFF_Fxxx,
// 3 = 0x0000_xxxx (overlaps 0 and 1, so it only wins outside them).
module tb_io_bus_fabric;

  localparam int M = 2;
  localparam int S = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 3;

  logic            clk;
  logic            rst;
  logic [M-1:0]    m_req;
  logic [M-1:0]    m_we;
  logic [M*AW-1:0] m_addr;
  logic [M*CW-1:0] m_ctrl;
  logic [M*DW-1:0] m_wd;
  logic [M-1:0]    m_ack;
  logic [M-1:0]    m_err;
  logic [DW-1:0]   m_rd;
  logic [S-1:0]    s_sel;
  logic            s_we;
  logic [AW-1:0]   s_addr;
  logic [CW-1:0]   s_ctrl;
  logic [DW-1:0]   s_wd;
  logic [S-1:0]    s_ack;
  logic [S*DW-1:0] s_rd;

  int total = 0;
  int bad = 0;

  // slave model controls
  int          wait_n;
  logic        ack_en;
  logic [S-1:0] noise;
  int          sel_cnt [S];

  io_bus_fabric #(
    .M(M), .S(S), .AW(AW), .DW(DW), .CW(CW),
    .SLV_BASE({32'h0000_0000, 32'hFFFF_F000, 32'h0000_1000, 32'h0000_0000}),
    .SLV_MASK({32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000}),
    .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_ctrl(m_ctrl), .m_wd(m_wd),
    .m_ack(m_ack), .m_err(m_err), .m_rd(m_rd),
    .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_ctrl(s_ctrl), .s_wd(s_wd),
    .s_ack(s_ack), .s_rd(s_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign s_rd = {32'h3333_3333, 32'h0000_00A5, 32'h2222_2222, 32'h1111_1111};

  // Slave acks after sel has been high for wait_n cycles; noise forces acks.
  always @(posedge clk) begin
    for (int i = 0; i < S; i++) sel_cnt[i] <= s_sel[i] ? sel_cnt[i] + 1 : 0;
  end

  always_comb begin
    s_ack = '0;
    for (int i = 0; i < S; i++)
      s_ack[i] = noise[i] | (ack_en & s_sel[i] & (sel_cnt[i] == wait_n));
  end

  typedef struct {
    int          mst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  ctrl;
    int          wait_c;
    logic        ack_on;
    logic [3:0]  nz;
    logic [3:0]  x_sel;
    int          x_nsel;
    int          x_lat;
    logic        x_err;
    logic [31:0] x_rd;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_master(input int i, input logic we, input logic [31:0] addr,
                            input logic [2:0] ctrl, input logic [31:0] wd);
    m_we[i] = we;
    m_addr[i*AW +: AW] = addr;
    m_ctrl[i*CW +: CW] = ctrl;
    m_wd[i*DW +: DW] = wd;
  endtask

  task automatic run_vec(input int n);
    vec_t v;
    int cyc, lat, nsel;
    logic [3:0] sel_seen;
    logic [1:0] xa;
    v = vecs[n];
    xa = 2'b01 << v.mst;
    @(negedge clk);
    wait_n = v.wait_c;
    ack_en = v.ack_on;
    noise = v.nz;
    set_master(v.mst, v.we, v.addr, v.ctrl, v.wd);
    set_master(1 - v.mst, ~v.we, ~v.addr, ~v.ctrl, ~v.wd);
    m_req = xa;
    cyc = 0; lat = -1; nsel = 0; sel_seen = '0;
    while (lat < 0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (s_sel != '0) begin
        if (nsel == 0) begin
          sel_seen = s_sel;
          chk($sformatf("v%0d_s_addr", n), 64'(s_addr), 64'(v.addr));
          chk($sformatf("v%0d_s_fields", n), 64'({s_we, s_ctrl, s_wd}),
              64'({v.we, v.ctrl, v.wd}));
        end
        nsel++;
      end
      if (m_ack != '0) begin
        lat = cyc;
        chk($sformatf("v%0d_m_ack", n), 64'(m_ack), 64'(xa));
        chk($sformatf("v%0d_m_err", n), 64'(m_err), 64'(v.x_err ? xa : 2'b00));
        chk($sformatf("v%0d_m_rd", n), 64'(m_rd), 64'(v.x_rd));
      end
    end
    m_req = '0;
    noise = '0;
    chk($sformatf("v%0d_latency", n), 64'(lat), 64'(v.x_lat));
    chk($sformatf("v%0d_sel_cycles", n), 64'(nsel), 64'(v.x_nsel));
    chk($sformatf("v%0d_sel_value", n), 64'(sel_seen), 64'(v.x_sel));
    @(posedge clk); #1;
    chk($sformatf("v%0d_ack_pulse", n), 64'(m_ack), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] xa;
    // fields: mst we addr wd ctrl wait ack_on noise | sel nsel lat err rd
    vecs[0] = '{0, 1'b0, 32'hFFFF_F060, 32'h0, 3'd2, 0, 1'b1, 4'b0000,
                4'b0100, 1, 2, 1'b0, 32'h0000_00A5};
    vecs[1] = '{1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3'd5, 2, 1'b1, 4'b0000,
                4'b0001, 3, 4, 1'b0, 32'h0};
    vecs[2] = '{1, 1'b0, 32'h1234_0000, 32'h0, 3'd1, 0, 1'b1, 4'b1111,
                4'b0000, 0, 1, 1'b1, 32'h0};
    vecs[3] = '{0, 1'b0, 32'h0000_1004, 32'h0, 3'd3, 1, 1'b1, 4'b0000,
                4'b0010, 2, 3, 1'b0, 32'h2222_2222};
    vecs[4] = '{1, 1'b0, 32'h0000_2000, 32'h0, 3'd4, 0, 1'b1, 4'b0000,
                4'b1000, 1, 2, 1'b0, 32'h3333_3333};
    vecs[5] = '{0, 1'b0, 32'h0000_0100, 32'h0, 3'd6, 0, 1'b1, 4'b0000,
                4'b0001, 1, 2, 1'b0, 32'h1111_1111};
    vecs[6] = '{0, 1'b0, 32'hFFFF_F004, 32'h0, 3'd7, 0, 1'b0, 4'b1011,
                4'b0100, 4, 5, 1'b1, 32'h0};
    vecs[7] = '{1, 1'b0, 32'h0000_1FFC, 32'h0, 3'd0, 3, 1'b1, 4'b0000,
                4'b0010, 4, 5, 1'b0, 32'h2222_2222};

    // reset with both masters requesting writes to slave 0
    rst = 1'b1;
    wait_n = 0; ack_en = 1'b1; noise = '0;
    m_we = '0; m_addr = '0; m_ctrl = '0; m_wd = '0;
    set_master(0, 1'b1, 32'h0000_0000, 3'd2, 32'hA0A0_A0A0);
    set_master(1, 1'b1, 32'h0000_0004, 3'd2, 32'hB0B0_B0B0);
    m_req = 2'b11;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk("rst_s_sel", 64'(s_sel), 64'(0));
      chk("rst_m_ack", 64'(m_ack), 64'(0));
      chk("rst_m_rd", 64'(m_rd), 64'(0));
    end

    // round-robin under continuous requests: acks at cycles 2,5,8,11
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      xa = 2'b00;
      if (c == 2 || c == 8) xa = 2'b01;
      if (c == 5 || c == 11) xa = 2'b10;
      chk($sformatf("rr_c%0d_m_ack", c), 64'(m_ack), 64'(xa));
      if (xa != 2'b00) begin
        chk($sformatf("rr_c%0d_m_err", c), 64'(m_err), 64'(0));
        chk($sformatf("rr_c%0d_m_rd", c), 64'(m_rd), 64'(0));
      end
    end
    @(negedge clk);
    m_req = '0;
    @(posedge clk); #1;

    for (int n = 0; n < 8; n++) run_vec(n);

    // timeout again, then a late ack from the timed-out slave
    run_vec(6);
    noise = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("late_ack_m_ack", 64'(m_ack), 64'(0));
      chk("late_ack_s_sel", 64'(s_sel), 64'(0));
    end
    noise = '0;

    // reset during wait cycle 2 of a master-1 access; rr_ptr is 1 here
    @(negedge clk);
    ack_en = 1'b0;
    set_master(1, 1'b0, 32'hFFFF_F000, 3'd0, 32'h0);
    m_req = 2'b10;
    @(posedge clk); #1;
    chk("rmid_sel_c1", 64'(s_sel), 64'(4'b0100));
    @(posedge clk); #1;
    chk("rmid_sel_c2", 64'(s_sel), 64'(4'b0100));
    @(negedge clk);
    rst = 1'b1;
    m_req = '0;
    @(posedge clk); #1;
    chk("rmid_after_s_sel", 64'(s_sel), 64'(0));
    chk("rmid_after_m_ack", 64'(m_ack), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    ack_en = 1'b1;
    wait_n = 0;
    set_master(0, 1'b0, 32'h0000_0000, 3'd0, 32'h0);
    set_master(1, 1'b0, 32'h0000_0004, 3'd0, 32'h0);
    m_req = 2'b11;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      xa = 2'b00;
      if (c == 2) xa = 2'b01;
      if (c == 5) xa = 2'b10;
      chk($sformatf("rpost_c%0d_m_ack", c), 64'(m_ack), 64'(xa));
      if (c == 2) chk("rpost_m_rd", 64'(m_rd), 64'(32'h1111_1111));
    end
    m_req = '0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
